// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite drawing stage.
// Holds screen size, default sprite geometry, FSM states and job types.
package sprite_pkg;

   localparam int SCREEN_W     = 320;
   localparam int SCREEN_H     = 240;
   localparam int DEF_SPRITE_W = 8;
   localparam int DEF_SPRITE_H = 8;
   localparam int DEF_COLOUR_W = 9;
   localparam int DEF_IMG_W    = DEF_SPRITE_W * DEF_SPRITE_H * DEF_COLOUR_W;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   typedef enum logic {
      BG   = 1'b0,
      CHAR = 1'b1
   } job_t;

   // Default character image: a single diagonal stroke, everything else
   // left at colour 0 (transparent with the default key).
   function automatic logic [DEF_IMG_W-1:0] diag_image();
      logic [DEF_IMG_W-1:0] img;
      img = '0;
      for (int i = 0; i < DEF_SPRITE_W; i++)
         img[(i*DEF_SPRITE_W + i)*DEF_COLOUR_W +: DEF_COLOUR_W] =
            DEF_COLOUR_W'(i + 1);
      return img;
   endfunction

   localparam logic [DEF_IMG_W-1:0] DEF_ROM_INIT = diag_image();

endpackage

// File: rtl/char_sprite_rom.sv
// char_sprite_rom: character image ROM, synchronous read, 1-cycle latency.
// Ports: clock; addr = cy*W + cx; data = colour of that pixel (next cycle).
module char_sprite_rom #(
   parameter int                     DEPTH = 64,
   parameter int                     WIDTH = 9,
   parameter int                     AW    = 6,
   parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
   input  logic             clock,
   input  logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] data
);

   // Image is fixed at elaboration; word k lives at bits [k*WIDTH +: WIDTH].
   always_ff @(posedge clock) begin
      data <= INIT[int'(addr)*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/sprite_drawer.sv
// sprite_drawer: redraws background or draws the character over an 8x8
// footprint, one pixel per clock to the VGA adapter, then pulses done.
// Ports: clock/reset; drawBG/drawChar level requests; x/yCoordinate anchor;
// bg_addr/bg_colour background RAM; vga_x/vga_y/vga_colour/plot to VGA;
// doneBG/doneChar one-cycle completion pulses.
module sprite_drawer
   import sprite_pkg::*;
#(
   parameter int SPRITE_W = DEF_SPRITE_W,
   parameter int SPRITE_H = DEF_SPRITE_H,
   parameter int COLOUR_W = DEF_COLOUR_W,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = '0,
   parameter logic [SPRITE_W*SPRITE_H*COLOUR_W-1:0] ROM_INIT = DEF_ROM_INIT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                drawBG,
   input  logic                drawChar,
   input  logic [8:0]          xCoordinate,
   input  logic [7:0]          yCoordinate,
   output logic [16:0]         bg_addr,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic [8:0]          vga_x,
   output logic [7:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                plot,
   output logic                doneBG,
   output logic                doneChar
);

   localparam int CXW = $clog2(SPRITE_W);
   localparam int CYW = $clog2(SPRITE_H);
   localparam int AW  = CXW + CYW;

   state_t state, state_n;
   job_t   job;

   logic                bg_q, ch_q, pend_bg, pend_ch;
   logic                bg_rise, ch_rise, start_bg, start_ch;
   logic signed [9:0]   tlx, tly, px, py;
   logic [CXW-1:0]      cx;
   logic [CYW-1:0]      cy;
   logic                last, on, scan, done_bg, done_ch;
   logic [16:0]         addr_calc;
   logic [COLOUR_W-1:0] rom_q, colour_i, hold_c;
   logic                s_v, plot_i;
   logic [8:0]          s_x, hold_x;
   logic [7:0]          s_y, hold_y;

   assign bg_rise  = drawBG & ~bg_q;
   assign ch_rise  = drawChar & ~ch_q;
   assign start_bg = (state == IDLE) & (bg_rise | pend_bg);
   assign start_ch = (state == IDLE) & ~start_bg & (ch_rise | pend_ch);

   assign last = (cx == CXW'(SPRITE_W - 1)) && (cy == CYW'(SPRITE_H - 1));
   assign px   = tlx + $signed({{(10-CXW){1'b0}}, cx});
   assign py   = tly + $signed({{(10-CYW){1'b0}}, cy});
   assign on   = !px[9] && (px < $signed(10'(SCREEN_W))) &&
                 !py[9] && (py < $signed(10'(SCREEN_H)));
   assign addr_calc = 17'(py[7:0]) * 17'(SCREEN_W) + 17'(px[8:0]);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_bg | start_ch) state_n = SCAN;
         SCAN:    if (last) state_n = DRAIN;
         DRAIN:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      scan    = 1'b0;
      done_bg = 1'b0;
      done_ch = 1'b0;
      case (state)
         SCAN: scan = 1'b1;
         DONE: begin
            done_bg = (job == BG);
            done_ch = (job == CHAR);
         end
         default: ;
      endcase
   end

   char_sprite_rom #(
      .DEPTH (SPRITE_W * SPRITE_H),
      .WIDTH (COLOUR_W),
      .AW    (AW),
      .INIT  (ROM_INIT)
   ) u_rom (
      .clock (clock),
      .addr  ({cy, cx}),
      .data  (rom_q)
   );

   // One-cycle read latency on both sources: s_* carry the pixel position
   // alongside the data returning from RAM/ROM.
   assign colour_i = (job == BG) ? bg_colour : rom_q;
   assign plot_i   = s_v & ((job == BG) | (rom_q != TRANSPARENT));

   always_ff @(posedge clock) begin
      if (reset) begin
         bg_q    <= 1'b0;
         ch_q    <= 1'b0;
         pend_bg <= 1'b0;
         pend_ch <= 1'b0;
         job     <= BG;
         tlx     <= '0;
         tly     <= '0;
         cx      <= '0;
         cy      <= '0;
         s_v     <= 1'b0;
         s_x     <= '0;
         s_y     <= '0;
         hold_x  <= '0;
         hold_y  <= '0;
         hold_c  <= '0;
      end else begin
         bg_q    <= drawBG;
         ch_q    <= drawChar;
         // Edges seen while busy wait here; a second one of the same type
         // merges into the flag already set.
         pend_bg <= start_bg ? 1'b0 : (pend_bg | bg_rise);
         pend_ch <= start_ch ? 1'b0 : (pend_ch | ch_rise);
         if (start_bg | start_ch) begin
            job <= start_bg ? BG : CHAR;
            tlx <= $signed({1'b0, xCoordinate}) - $signed(10'(SPRITE_W / 2));
            tly <= $signed({2'b0, yCoordinate}) - $signed(10'(SPRITE_H - 1));
            cx  <= '0;
            cy  <= '0;
         end else if (scan) begin
            cx <= cx + 1'b1;
            if (cx == CXW'(SPRITE_W - 1)) cy <= cy + 1'b1;
         end
         s_v <= scan & on;
         s_x <= px[8:0];
         s_y <= py[7:0];
         // Keep the last plotted pixel so vga_* stay put between plots.
         if (plot_i) begin
            hold_x <= s_x;
            hold_y <= s_y;
            hold_c <= colour_i;
         end
      end
   end

   // Everything reads 0 while reset is held.
   assign bg_addr    = (scan & on & ~reset) ? addr_calc : '0;
   assign plot       = plot_i & ~reset;
   assign vga_x      = reset ? '0 : (plot_i ? s_x : hold_x);
   assign vga_y      = reset ? '0 : (plot_i ? s_y : hold_y);
   assign vga_colour = reset ? '0 : (plot_i ? colour_i : hold_c);
   assign doneBG     = done_bg & ~reset;
   assign doneChar   = done_ch & ~reset;

endmodule
